// File: rtl/peripheral_opsequencer.sv
// Operand/result sequencer between board I/O and the 32-bit arithmetic unit.
// Debounces the enter key, loads A and B byte-serially (LSB first), strobes the
// arithmetic unit, waits for its result (or times out), then lets the user step
// through the bytes of A, B and R on the 7-segment display path.
module peripheral_opsequencer #(
    parameter int DEBOUNCE = 4,     // cycles enter must be stable before a level change is accepted
    parameter int TIMEOUT  = 1024   // max cycles in WAIT before aborting with alu_err
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enter,
    input  logic        loaddata,
    input  logic [7:0]  inputdata,
    input  logic        alu_done,
    input  logic [31:0] dataR,
    output logic [31:0] dataA,
    output logic [31:0] dataB,
    output logic        alu_start,
    output logic        inputdata_ready,
    output logic        alu_err,
    output logic [7:0]  dataoutput,
    output logic [3:0]  pos
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {LOAD_A, LOAD_B, START, WAIT, SHOW} state_t;

    state_t          state, state_next;
    logic            sync1, sync2, stable, stable_d, press;
    logic [DW-1:0]   db_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [1:0]      idx;      // load byte index, and display byte index in SHOW
    logic [1:0]      sel;      // display source in SHOW: 00=A, 01=B, 10=R
    logic [31:0]     data_r;
    logic [7:0]      shown_byte;
    logic            timeout_hit;

    assign timeout_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    // Synchronise enter, filter bounce, and emit a one-cycle pulse on each accepted press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            press    <= 1'b0;
            db_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every flop samples the pre-edge value of the others.
            sync1    <= enter;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            if (sync2 != stable) begin
                if (db_cnt == DW'(DEBOUNCE - 1)) begin
                    stable <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD_A;
        else        state <= state_next;
    end

    // Byte selected by the display cursor while in SHOW.
    always_comb begin
        shown_byte = 8'h00;
        case (sel)
            2'b00:   shown_byte = dataA[{idx, 3'b000} +: 8];
            2'b01:   shown_byte = dataB[{idx, 3'b000} +: 8];
            2'b10:   shown_byte = data_r[{idx, 3'b000} +: 8];
            default: shown_byte = 8'h00;
        endcase
    end

    // Next-state decode and display/strobe outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        state_next = state;
        alu_start  = 1'b0;
        dataoutput = inputdata;
        pos        = 4'b1000;
        case (state)
            LOAD_A: begin
                pos = {2'b00, idx};
                if (press && loaddata && idx == 2'd3) state_next = LOAD_B;
            end
            LOAD_B: begin
                pos = {2'b01, idx};
                if (press && loaddata && idx == 2'd3) state_next = START;
            end
            START: begin
                alu_start  = 1'b1;
                dataoutput = 8'h00;
                state_next = WAIT;
            end
            WAIT: begin
                dataoutput = 8'h00;
                if (alu_done || timeout_hit) state_next = SHOW;
            end
            SHOW: begin
                pos        = {sel, idx};
                dataoutput = shown_byte;
                if (press && loaddata) state_next = LOAD_A;
            end
            default: state_next = LOAD_A;
        endcase
    end

    // Operand/result registers, byte index, display cursor, timeout and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataA           <= '0;
            dataB           <= '0;
            data_r          <= '0;
            idx             <= '0;
            sel             <= '0;
            tmo_cnt         <= '0;
            inputdata_ready <= 1'b0;
            alu_err         <= 1'b0;
        end else begin
            case (state)
                LOAD_A: if (press && loaddata) begin
                    dataA[{idx, 3'b000} +: 8] <= inputdata;
                    idx <= idx + 1'b1;          // wraps to 0 after byte 3, ready for LOAD_B
                end
                LOAD_B: if (press && loaddata) begin
                    dataB[{idx, 3'b000} +: 8] <= inputdata;
                    idx <= idx + 1'b1;
                end
                START: begin
                    alu_err <= 1'b0;
                    tmo_cnt <= '0;
                end
                WAIT: begin
                    // Presses are deliberately ignored here, even alongside alu_done.
                    if (alu_done) begin
                        data_r          <= dataR;
                        inputdata_ready <= 1'b1;
                        sel             <= 2'b00;
                        idx             <= 2'd0;
                    end else if (timeout_hit) begin
                        data_r          <= '0;
                        alu_err         <= 1'b1;
                        inputdata_ready <= 1'b1;
                        sel             <= 2'b00;
                        idx             <= 2'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                SHOW: if (press) begin
                    if (loaddata) begin
                        inputdata_ready <= 1'b0;
                        idx             <= 2'd0;
                        sel             <= 2'b00;
                    end else begin
                        idx <= idx + 1'b1;
                        if (idx == 2'd3) sel <= (sel == 2'b10) ? 2'b00 : sel + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_opsequencer.sv
// Directed bench for peripheral_opsequencer (DEBOUNCE=4, TIMEOUT=16).
module tb_peripheral_opsequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enter;
    logic        loaddata;
    logic [7:0]  inputdata;
    logic        alu_done;
    logic [31:0] dataR;
    logic [31:0] dataA, dataB;
    logic        alu_start, inputdata_ready, alu_err;
    logic [7:0]  dataoutput;
    logic [3:0]  pos;

    int n_tests     = 0;
    int n_fail      = 0;
    int start_count = 0;

    // Bytes shown at cursor positions 0..11 after loading A=3F800000, B=A1BE867D, R=C2820000.
    logic [7:0] exp_show [12] = '{8'h00, 8'h00, 8'h80, 8'h3F,
                                  8'h7D, 8'h86, 8'hBE, 8'hA1,
                                  8'h00, 8'h00, 8'h82, 8'hC2};

    always #5 clk = ~clk;

    peripheral_opsequencer #(.DEBOUNCE(4), .TIMEOUT(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .enter          (enter),
        .loaddata       (loaddata),
        .inputdata      (inputdata),
        .alu_done       (alu_done),
        .dataR          (dataR),
        .dataA          (dataA),
        .dataB          (dataB),
        .alu_start      (alu_start),
        .inputdata_ready(inputdata_ready),
        .alu_err        (alu_err),
        .dataoutput     (dataoutput),
        .pos            (pos)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; counts start strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        if (alu_start === 1'b1) start_count++;
    endtask

    // Clean press: hold 10 cycles, release 10 cycles. Write lands 8 edges after enter rises.
    task automatic press(input logic [7:0] v, input logic ld);
        inputdata = v;
        loaddata  = ld;
        enter     = 1'b1;
        repeat (10) tick();
        enter = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        reset     = 1'b0;
        enter     = 1'b0;
        loaddata  = 1'b1;
        inputdata = 8'h5A;
        alu_done  = 1'b0;
        dataR     = 32'h0;
        repeat (3) tick();

        // Reset state
        check("rst_dataA", dataA, 32'h0);
        check("rst_dataB", dataB, 32'h0);
        check("rst_pos", 32'(pos), 32'h0);
        check("rst_ready", 32'(inputdata_ready), 32'h0);
        check("rst_start", 32'(alu_start), 32'h0);
        check("rst_err", 32'(alu_err), 32'h0);
        check("rst_echo", 32'(dataoutput), 32'h5A);
        reset = 1'b1;
        repeat (2) tick();

        // Press with loaddata=0 in LOAD_A is dropped
        press(8'hAA, 1'b0);
        check("ld0_pos", 32'(pos), 32'h0);
        check("ld0_dataA", dataA, 32'h0);

        // Bounce: 20 cycles of toggling, then held high; exactly one write, 8 edges after settling
        loaddata  = 1'b1;
        inputdata = 8'h00;
        for (int i = 0; i < 20; i++) begin
            enter = ~enter;
            tick();
        end
        enter = 1'b1;
        repeat (7) tick();
        check("bounce_before", 32'(pos), 32'h0);
        tick();
        check("bounce_write", 32'(pos), 32'h1);
        repeat (10) tick();
        check("bounce_hold", 32'(pos), 32'h1);
        enter = 1'b0;
        repeat (10) tick();
        check("bounce_release", 32'(pos), 32'h1);

        // Finish A and B; alu_done held early (ignored until WAIT)
        press(8'h00, 1'b1);
        press(8'h80, 1'b1);
        press(8'h3F, 1'b1);
        check("loadA_dataA", dataA, 32'h3F800000);
        check("loadA_pos", 32'(pos), 32'h4);
        press(8'h7D, 1'b1);
        press(8'h86, 1'b1);
        press(8'hBE, 1'b1);
        check("loadB_pos", 32'(pos), 32'h7);
        start_count = 0;
        dataR       = 32'hC2820000;
        alu_done    = 1'b1;
        press(8'hA1, 1'b1);
        alu_done = 1'b0;
        check("loadB_dataB", dataB, 32'hA1BE867D);
        check("start_pulses", 32'(start_count), 32'h1);
        check("done_ready", 32'(inputdata_ready), 32'h1);
        check("done_err", 32'(alu_err), 32'h0);
        check("show_pos0", 32'(pos), 32'h0);
        check("show_byte0", 32'(dataoutput), 32'h00);

        // Step the cursor through A0..R3, then wrap
        for (int i = 1; i < 12; i++) begin
            press(8'h00, 1'b0);
            check($sformatf("step_pos%0d", i), 32'(pos), 32'(i));
            check($sformatf("step_byte%0d", i), 32'(dataoutput), 32'(exp_show[i]));
        end
        press(8'h00, 1'b0);
        check("wrap_pos", 32'(pos), 32'h0);
        check("wrap_byte", 32'(dataoutput), 32'h00);

        // Restart, then run into timeout
        press(8'h00, 1'b1);
        check("restart_ready", 32'(inputdata_ready), 32'h0);
        check("restart_pos", 32'(pos), 32'h0);
        check("restart_keepA", dataA, 32'h3F800000);
        press(8'h11, 1'b1);
        press(8'h22, 1'b1);
        press(8'h33, 1'b1);
        press(8'h44, 1'b1);
        press(8'h55, 1'b1);
        press(8'h66, 1'b1);
        press(8'h77, 1'b1);
        start_count = 0;
        press(8'h88, 1'b1);             // START after edge 8, WAIT from edge 9, now edge 20
        check("tmo_start_pulses", 32'(start_count), 32'h1);
        check("tmo_wait_pos", 32'(pos), 32'h8);
        check("tmo_wait_byte", 32'(dataoutput), 32'h00);
        check("tmo_wait_ready", 32'(inputdata_ready), 32'h0);
        repeat (4) tick();              // edge 24: 15 WAIT cycles elapsed
        check("tmo_not_yet", 32'(inputdata_ready), 32'h0);
        tick();                         // edge 25: 16th WAIT cycle ends
        check("tmo_ready", 32'(inputdata_ready), 32'h1);
        check("tmo_err", 32'(alu_err), 32'h1);
        check("tmo_pos", 32'(pos), 32'h0);
        check("tmo_byteA0", 32'(dataoutput), 32'h11);
        check("tmo_dataA", dataA, 32'h44332211);
        check("tmo_dataB", dataB, 32'h88776655);
        repeat (8) press(8'h00, 1'b0);
        check("tmo_R0_pos", 32'(pos), 32'h8);
        check("tmo_R0", 32'(dataoutput), 32'h00);
        repeat (3) press(8'h00, 1'b0);
        check("tmo_R3", 32'(dataoutput), 32'h00);

        // Restart: alu_err holds until START, then clears; press coincident with done is dropped
        press(8'h00, 1'b1);
        check("err_hold", 32'(alu_err), 32'h1);
        press(8'h01, 1'b1);
        press(8'h02, 1'b1);
        press(8'h03, 1'b1);
        press(8'h04, 1'b1);
        press(8'h05, 1'b1);
        press(8'h06, 1'b1);
        press(8'h07, 1'b1);
        start_count = 0;
        inputdata = 8'h08;
        loaddata  = 1'b1;
        enter     = 1'b1;
        repeat (5) tick();
        enter = 1'b0;
        repeat (4) tick();              // edge 9: in WAIT
        check("clr_start_pulses", 32'(start_count), 32'h1);
        check("clr_err", 32'(alu_err), 32'h0);
        check("clr_wait_pos", 32'(pos), 32'h8);
        repeat (3) tick();              // edge 12
        loaddata = 1'b0;
        enter    = 1'b1;                // pulse acts at edge 20
        repeat (5) tick();
        enter = 1'b0;
        repeat (2) tick();              // edge 19
        dataR    = 32'hCAFEF00D;
        alu_done = 1'b1;
        tick();                         // edge 20: done and press together
        alu_done = 1'b0;
        check("coinc_ready", 32'(inputdata_ready), 32'h1);
        check("coinc_pos", 32'(pos), 32'h0);
        check("coinc_byte", 32'(dataoutput), 32'h01);
        repeat (12) tick();
        check("coinc_pos_after", 32'(pos), 32'h0);
        repeat (8) press(8'h00, 1'b0);
        check("coinc_R0", 32'(dataoutput), 32'h0D);

        // Asynchronous reset in the middle of WAIT
        press(8'h00, 1'b1);
        press(8'h9A, 1'b1);
        press(8'hBC, 1'b1);
        press(8'hDE, 1'b1);
        press(8'hF0, 1'b1);
        press(8'h12, 1'b1);
        press(8'h34, 1'b1);
        press(8'h56, 1'b1);
        press(8'h78, 1'b1);             // now in WAIT
        check("midwait_pos", 32'(pos), 32'h8);
        inputdata = 8'hC3;
        reset     = 1'b0;
        #1;
        check("arst_dataA", dataA, 32'h0);
        check("arst_dataB", dataB, 32'h0);
        check("arst_pos", 32'(pos), 32'h0);
        check("arst_ready", 32'(inputdata_ready), 32'h0);
        check("arst_start", 32'(alu_start), 32'h0);
        check("arst_echo", 32'(dataoutput), 32'hC3);
        reset = 1'b1;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
